dec_seq: RTL and testbench

- Parametrised, registered N-to-2^N one-hot decoder with enable, a valid/ready input handshake and an auto-scan mode.
- Scan mode steps the decoded output through every code with a programmable dwell time.
- Serves as the row/digit select driver for multiplexed displays and keypad scanners in the combinational-circuits library.
- Successor to the fixed 3x8 enable decoder: adds width generality, registered outputs and sequencing.

---
 rtl/dec_seq_if.sv | 37 +++
 rtl/dec_seq.sv | 149 ++++++++++++++
 tb/tb_dec_seq.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dec_seq_if.sv
// dec_seq_if - handshake/data bundle for the dec_seq decoder/sequencer.
//
// Parameters:
//   N       - input code width; y is 2^N bits wide
//   DWELL_W - width of the scan dwell value
//
// Signals:
//   en, mode, i_valid, i, dwell : driven by the controller (master)
//   i_ready, y, code, wrap      : driven by dec_seq (slave)
//
// Modports:
//   master - controller side (testbench or parent logic)
//   slave  - dec_seq side
interface dec_seq_if #(
    parameter int N       = 3,
    parameter int DWELL_W = 4
);
    logic                 en;
    logic                 mode;
    logic                 i_valid;
    logic                 i_ready;
    logic [N-1:0]         i;
    logic [DWELL_W-1:0]   dwell;
    logic [(1<<N)-1:0]    y;
    logic [N-1:0]         code;
    logic                 wrap;

    modport master (
        output en, mode, i_valid, i, dwell,
        input  i_ready, y, code, wrap
    );

    modport slave (
        input  en, mode, i_valid, i, dwell,
        output i_ready, y, code, wrap
    );
endinterface

// File: rtl/dec_seq.sv
// dec_seq - registered N-to-2^N one-hot decoder with enable, valid/ready
// input handshake and an auto-scan mode with programmable dwell time.
//
// Ports:
//   clk   - system clock, all state updates on the rising edge
//   rst_n - synchronous active-low reset, sampled on the rising edge
//   bus   - dec_seq_if.slave:
//             en      block enable, 0 blanks y and returns to IDLE
//             mode    0 = direct decode, 1 = auto-scan
//             i_valid input code valid (direct mode)
//             i_ready combinational: en & ~mode & rst_n
//             i       code to decode
//             dwell   scan cycles per code minus 1
//             y       registered one-hot output
//             code    code currently driving y
//             wrap    one-cycle pulse when the scan wraps to code 0
//
// Build option:
//   DEC_SEQ_OUT_INV_EN - when defined, y is driven active-low (bitwise
//                        inverse of the one-hot value); reset/blank value
//                        becomes all-ones. code, wrap, i_ready unchanged.
module dec_seq #(
    parameter int N       = 3,
    parameter int DWELL_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    dec_seq_if.slave    bus
);

    localparam int W = 1 << N;

    // Output polarity mask: XOR-ing the one-hot value with this mask gives
    // the value actually driven on y.
`ifdef DEC_SEQ_OUT_INV_EN
    localparam logic [W-1:0] Y_POL = {W{1'b1}};
`else
    localparam logic [W-1:0] Y_POL = {W{1'b0}};
`endif

    localparam logic [N-1:0]       CODE_ZERO  = {N{1'b0}};
    localparam logic [N-1:0]       CODE_ONE   = N'(1'b1);
    localparam logic [N-1:0]       CODE_MAX   = {N{1'b1}};
    localparam logic [DWELL_W-1:0] DWELL_ZERO = {DWELL_W{1'b0}};
    localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1'b1);
    localparam logic [W-1:0]       HOT_ZERO   = {W{1'b0}};
    localparam logic [W-1:0]       HOT_ONE    = W'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [N-1:0]         code_r;
    logic [N-1:0]         code_nxt_s;
    logic [DWELL_W-1:0]   cnt_r;
    logic [DWELL_W-1:0]   cnt_nxt_s;
    logic [W-1:0]         y_r;
    logic [W-1:0]         hot_cur_s;
    logic [W-1:0]         hot_nxt_s;
    logic                 wrap_r;
    logic                 wrap_nxt_s;
    logic                 ready_s;

    // One-hot image of a code.
    function automatic logic [W-1:0] onehot(input logic [N-1:0] c);
        onehot = HOT_ONE << c;
    endfunction

    // Handshake ready is combinational so a transfer can complete in the
    // very first enabled cycle, including straight out of IDLE.
    assign ready_s     = bus.en & ~bus.mode & rst_n;
    assign bus.i_ready = ready_s;

    // Current one-hot value with the output polarity stripped off.
    assign hot_cur_s = y_r ^ Y_POL;

    // Next-state and next-output logic; priority is en > mode > i_valid.
    always_comb begin
        state_nxt_s = state_r;
        code_nxt_s  = code_r;
        cnt_nxt_s   = cnt_r;
        hot_nxt_s   = hot_cur_s;
        wrap_nxt_s  = 1'b0;

        if (!bus.en) begin
            // Blank and park; code is deliberately left holding.
            state_nxt_s = ST_IDLE;
            hot_nxt_s   = HOT_ZERO;
            cnt_nxt_s   = DWELL_ZERO;
        end else if (bus.mode) begin
            state_nxt_s = ST_SCAN;
            if (state_r != ST_SCAN) begin
                // Scan entry always restarts from code 0.
                code_nxt_s = CODE_ZERO;
                hot_nxt_s  = onehot(CODE_ZERO);
                cnt_nxt_s  = bus.dwell;
            end else if (cnt_r == DWELL_ZERO) begin
                // Dwell expired: advance, reload from the live dwell value.
                code_nxt_s = code_r + CODE_ONE;
                hot_nxt_s  = onehot(code_r + CODE_ONE);
                cnt_nxt_s  = bus.dwell;
                wrap_nxt_s = (code_r == CODE_MAX);
            end else begin
                cnt_nxt_s = cnt_r - DWELL_ONE;
            end
        end else begin
            state_nxt_s = ST_DIRECT;
            // Leaving scan clears the dwell counter; y/code hold.
            if (state_r == ST_SCAN) begin
                cnt_nxt_s = DWELL_ZERO;
            end else begin
                cnt_nxt_s = cnt_r;
            end
            // ready is necessarily 1 here (en=1, mode=0, out of reset).
            if (bus.i_valid) begin
                code_nxt_s = bus.i;
                hot_nxt_s  = onehot(bus.i);
            end else begin
                code_nxt_s = code_r;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            code_r  <= CODE_ZERO;
            cnt_r   <= DWELL_ZERO;
            y_r     <= Y_POL;
            wrap_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            code_r  <= code_nxt_s;
            cnt_r   <= cnt_nxt_s;
            y_r     <= hot_nxt_s ^ Y_POL;
            wrap_r  <= wrap_nxt_s;
        end
    end

    assign bus.y    = y_r;
    assign bus.code = code_r;
    assign bus.wrap = wrap_r;

endmodule

// File: tb/tb_dec_seq.sv
// tb_dec_seq - directed self-checking bench for dec_seq (N=3, DWELL_W=4).
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, well away from the next edge.
module tb_dec_seq;

`ifdef DEC_SEQ_OUT_INV_EN
    localparam logic [7:0] YP = 8'hFF;
`else
    localparam logic [7:0] YP = 8'h00;
`endif

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    dec_seq_if #(.N(3), .DWELL_W(4)) bus ();

    dec_seq #(.N(3), .DWELL_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected y for a given displayed code, in the build's polarity.
    function automatic logic [7:0] ye(input int c);
        logic [7:0] one;
        one = 8'h01;
        return (one << c) ^ YP;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        bus.en = 1'b0; bus.mode = 1'b0; bus.i_valid = 1'b0;
        bus.i = 3'd0; bus.dwell = 4'd0;

        // Reset state
        tick(); tick();
        check("rst_y", {24'd0, bus.y}, {24'd0, YP});
        check("rst_code", {29'd0, bus.code}, 32'd0);
        check("rst_wrap", {31'd0, bus.wrap}, 32'd0);
        bus.en = 1'b1;
        #1;
        check("rst_ready", {31'd0, bus.i_ready}, 32'd0);

        // Direct decode of every code, one per cycle
        rst_n = 1'b1;
        #1;
        check("ready_on", {31'd0, bus.i_ready}, 32'd1);
        for (int k = 0; k < 8; k++) begin
            bus.i = 3'(k); bus.i_valid = 1'b1;
            tick();
            check("dir_y", {24'd0, bus.y}, {24'd0, ye(k)});
            check("dir_code", {29'd0, bus.code}, 32'(k));
            check("dir_ready", {31'd0, bus.i_ready}, 32'd1);
        end

        // No transfer holds; then accept i=5
        bus.i = 3'd5; bus.i_valid = 1'b0;
        tick();
        check("hold_y", {24'd0, bus.y}, {24'd0, ye(7)});
        check("hold_code", {29'd0, bus.code}, 32'd7);
        bus.i_valid = 1'b1;
        tick();
        check("acc5_y", {24'd0, bus.y}, {24'd0, 8'h20 ^ YP});
        check("acc5_code", {29'd0, bus.code}, 32'd5);

        // Scan with dwell=2: 3 cycles per code, wrap on second code 0
        bus.i_valid = 1'b0; bus.dwell = 4'd2; bus.mode = 1'b1;
        tick();
        for (int t = 0; t <= 25; t++) begin
            if (t > 0) tick();
            check("scan2_code", {29'd0, bus.code}, 32'((t / 3) % 8));
            check("scan2_y", {24'd0, bus.y}, {24'd0, ye((t / 3) % 8)});
            check("scan2_wrap", {31'd0, bus.wrap}, (t == 24) ? 32'd1 : 32'd0);
        end
        check("scan_ready", {31'd0, bus.i_ready}, 32'd0);

        // en=0 blanks, then scan with dwell=0
        bus.en = 1'b0;
        tick();
        check("blank_y", {24'd0, bus.y}, {24'd0, YP});
        bus.dwell = 4'd0; bus.en = 1'b1;
        tick();
        check("scan0_entry", {29'd0, bus.code}, 32'd0);
        for (int t = 1; t <= 19; t++) begin
            tick();
            check("scan0_code", {29'd0, bus.code}, 32'(t % 8));
            check("scan0_wrap", {31'd0, bus.wrap}, (t % 8 == 0) ? 32'd1 : 32'd0);
        end
        // code is 3 here; drop en mid-scan
        bus.en = 1'b0;
        tick();
        check("drop_y", {24'd0, bus.y}, {24'd0, YP});
        check("drop_code", {29'd0, bus.code}, 32'd3);
        check("drop_wrap", {31'd0, bus.wrap}, 32'd0);
        bus.en = 1'b1;
        tick();
        check("restart_code", {29'd0, bus.code}, 32'd0);
        check("restart_y", {24'd0, bus.y}, {24'd0, ye(0)});

        // Reset while scanning at code 6
        for (int t = 0; t < 6; t++) tick();
        check("pre_rst_code", {29'd0, bus.code}, 32'd6);
        rst_n = 1'b0;
        #1;
        check("rst_between_y", {24'd0, bus.y}, {24'd0, ye(6)});
        tick();
        check("mid_rst_y", {24'd0, bus.y}, {24'd0, YP});
        check("mid_rst_code", {29'd0, bus.code}, 32'd0);
        check("mid_rst_wrap", {31'd0, bus.wrap}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_y", {24'd0, bus.y}, {24'd0, ye(0)});

        // Dwell change applies only at the next reload
        bus.en = 1'b0;
        tick();
        bus.dwell = 4'd1; bus.en = 1'b1;
        tick();
        bus.dwell = 4'd3;
        begin
            int exp_c [6] = '{0, 1, 1, 1, 1, 2};
            for (int t = 0; t < 6; t++) begin
                tick();
                check("dwell_chg_code", {29'd0, bus.code}, 32'(exp_c[t]));
            end
        end

        // Scan -> direct holds, then accept; mode beats i_valid
        bus.mode = 1'b0; bus.i_valid = 1'b0;
        #1;
        check("s2d_ready", {31'd0, bus.i_ready}, 32'd1);
        tick();
        check("s2d_hold_code", {29'd0, bus.code}, 32'd2);
        check("s2d_hold_y", {24'd0, bus.y}, {24'd0, ye(2)});
        bus.i = 3'd4; bus.i_valid = 1'b1;
        tick();
        check("s2d_acc_code", {29'd0, bus.code}, 32'd4);
        check("s2d_acc_y", {24'd0, bus.y}, {24'd0, ye(4)});
        bus.i = 3'd7; bus.mode = 1'b1;
        tick();
        check("prio_code", {29'd0, bus.code}, 32'd0);
        check("prio_y", {24'd0, bus.y}, {24'd0, ye(0)});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
